vga_console: RTL

VGA_CONSOLE -- requirements
Module: vga_console

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_console.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vga_pkg.sv
// Shared geometry defaults, control codes and FSM encoding for the VGA text console.
package vga_pkg;

    localparam int DEF_COLS = 64;
    localparam int DEF_ROWS = 24;

    localparam logic [7:0] CODE_BS    = 8'h08;
    localparam logic [7:0] CODE_LF    = 8'h0A;
    localparam logic [7:0] CODE_FF    = 8'h0C;
    localparam logic [7:0] CODE_CR    = 8'h0D;
    localparam logic [7:0] CODE_SPACE = 8'h20;
    localparam logic [7:0] CODE_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLR_ROW    = 2'd1,
        CLR_SCREEN = 2'd2
    } state_t;

endpackage

// File: rtl/vga_console.sv
// Byte-stream text console: interprets characters and control codes and emits
// one registered character-cell write per cycle into the VGA character RAM.
module vga_console
    import vga_pkg::*;
#(
    parameter int          COLS       = DEF_COLS,
    parameter int          ROWS       = DEF_ROWS,
    parameter logic [23:0] DEFAULT_FG = 24'hFFFFFF,
    parameter logic [23:0] DEFAULT_BG = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        clear_req,
    input  logic        cfg_we,
    input  logic [23:0] cfg_fg,
    input  logic [23:0] cfg_bg,
    output logic        busy,
    output logic [5:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        charWr,
    output logic [23:0] charWrFgColor,
    output logic [23:0] charWrBgColor,
    output logic [7:0]  charWrCode,
    output logic [5:0]  charWrX,
    output logic [4:0]  charWrY
);

    localparam logic [5:0] X_LAST = 6'(COLS - 1);
    localparam logic [4:0] Y_LAST = 5'(ROWS - 1);

    state_t      state;
    logic [5:0]  clr_x;
    logic [4:0]  clr_y;
    logic [23:0] fg;
    logic [23:0] bg;
    logic [4:0]  next_row;
    logic        printable;

    // clear_req wins over a pending byte, so the byte stays unaccepted that cycle.
    assign in_ready  = (state == IDLE) && !clear_req;
    assign busy      = (state != IDLE);
    assign next_row  = (cursor_y == Y_LAST) ? 5'd0 : cursor_y + 5'd1;
    assign printable = (in_data >= CODE_SPACE) && (in_data <= CODE_TILDE);

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // mixing in blocking assignments would make later statements see updated values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= CLR_SCREEN;
            clr_x         <= '0;
            clr_y         <= '0;
            cursor_x      <= '0;
            cursor_y      <= '0;
            fg            <= DEFAULT_FG;
            bg            <= DEFAULT_BG;
            charWr        <= 1'b0;
            charWrFgColor <= '0;
            charWrBgColor <= '0;
            charWrCode    <= '0;
            charWrX       <= '0;
            charWrY       <= '0;
        end else begin
            charWr <= 1'b0;
            if (cfg_we) begin
                fg <= cfg_fg;
                bg <= cfg_bg;
            end

            case (state)
                IDLE: begin
                    if (clear_req || (in_valid && in_data == CODE_FF)) begin
                        cursor_x <= '0;
                        cursor_y <= '0;
                        clr_x    <= '0;
                        clr_y    <= '0;
                        state    <= CLR_SCREEN;
                    end else if (in_valid) begin
                        if (in_data == CODE_LF) begin
                            cursor_x <= '0;
                            cursor_y <= next_row;
                            clr_x    <= '0;
                            state    <= CLR_ROW;
                        end else if (in_data == CODE_CR) begin
                            cursor_x <= '0;
                        end else if (in_data == CODE_BS) begin
                            if (cursor_x != 6'd0) begin
                                cursor_x      <= cursor_x - 6'd1;
                                charWr        <= 1'b1;
                                charWrFgColor <= fg;
                                charWrBgColor <= bg;
                                charWrCode    <= CODE_SPACE;
                                charWrX       <= cursor_x - 6'd1;
                                charWrY       <= cursor_y;
                            end
                        end else if (printable) begin
                            charWr        <= 1'b1;
                            charWrFgColor <= fg;
                            charWrBgColor <= bg;
                            charWrCode    <= in_data;
                            charWrX       <= cursor_x;
                            charWrY       <= cursor_y;
                            // Writing the last column wraps like LF, including the row clear.
                            if (cursor_x == X_LAST) begin
                                cursor_x <= '0;
                                cursor_y <= next_row;
                                clr_x    <= '0;
                                state    <= CLR_ROW;
                            end else begin
                                cursor_x <= cursor_x + 6'd1;
                            end
                        end
                    end
                end

                CLR_ROW: begin
                    charWr        <= 1'b1;
                    charWrFgColor <= fg;
                    charWrBgColor <= bg;
                    charWrCode    <= CODE_SPACE;
                    charWrX       <= clr_x;
                    charWrY       <= cursor_y;
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        state <= IDLE;
                    end else begin
                        clr_x <= clr_x + 6'd1;
                    end
                end

                CLR_SCREEN: begin
                    charWr        <= 1'b1;
                    charWrFgColor <= fg;
                    charWrBgColor <= bg;
                    charWrCode    <= CODE_SPACE;
                    charWrX       <= clr_x;
                    charWrY       <= clr_y;
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        if (clr_y == Y_LAST) begin
                            clr_y <= '0;
                            state <= IDLE;
                        end else begin
                            clr_y <= clr_y + 5'd1;
                        end
                    end else begin
                        clr_x <= clr_x + 6'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
